// File: rtl/gates_pkg.sv
// Shared types for the gates block and its built-in self-test driver/checker.
package gates_pkg;

  localparam int unsigned GATES_W = 4;

  typedef struct packed {
    logic               s;
    logic [GATES_W-1:0] a;
    logic [GATES_W-1:0] b;
  } gates_vec_t;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SETTLE,
    CHECK,
    DONE
  } bist_state_t;

  typedef struct packed {
    logic [GATES_W-1:0] y7;
    logic [GATES_W-1:0] y6;
    logic [GATES_W-1:0] y5;
    logic [GATES_W-1:0] y4;
    logic [GATES_W-1:0] y3;
    logic [GATES_W-1:0] y2;
    logic [GATES_W-1:0] y1;
  } gates_out_t;

endpackage

// File: rtl/gates_ref_model.sv
// Combinational golden model of the gates block outputs for a given {s,a,b}.
module gates_ref_model
  import gates_pkg::*;
(
  input  logic [GATES_W-1:0] a,
  input  logic [GATES_W-1:0] b,
  input  logic               s,
  output gates_out_t         y_exp
);

  always_comb begin
    y_exp    = '0;
    y_exp.y1 = a & b;
    y_exp.y2 = a | b;
    y_exp.y3 = a ^ b;
    y_exp.y4 = ~(a | b);
    y_exp.y5 = ~(a & b);
    y_exp.y6 = ~(a ^ b);
    // y7 only carries a value while the tristate is enabled
    y_exp.y7 = s ? a : '0;
  end

endmodule

// File: rtl/gates_bist.sv
// BIST driver/checker for the gates block: sweeps every {s,a,b}, checks y outputs.
// Define GATES_BIST_EXT_EN to also check y6 and the y7 tristate output.
module gates_bist
  import gates_pkg::*;
#(
  parameter int unsigned W             = GATES_W,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned ERR_W         = 8,
  parameter bit          STOP_ON_FAIL  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [W-1:0]     a,
  output logic [W-1:0]     b,
  output logic             s,
  input  logic [W-1:0]     y1,
  input  logic [W-1:0]     y2,
  input  logic [W-1:0]     y3,
  input  logic [W-1:0]     y4,
  input  logic [W-1:0]     y5,
  input  logic [W-1:0]     y6,
  input  logic [W-1:0]     y7,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [2*W:0]     fail_vec,
  output logic [6:0]       fail_mask
);

  localparam int unsigned VEC_W = 2 * W + 1;
  localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);

  bist_state_t      state;
  logic [VEC_W-1:0] idx;
  logic [CNT_W-1:0] cnt;
  gates_vec_t       vec_c;
  gates_out_t       y_exp;
  logic [6:0]       mask_c;
  logic             mismatch_c;
  logic             last_c;

  assign vec_c = idx;

  gates_ref_model u_ref (
    .a     (a),
    .b     (b),
    .s     (s),
    .y_exp (y_exp)
  );

  // Case-inequality so X/Z on a checked output counts as a mismatch in simulation
  always_comb begin
    mask_c    = '0;
    mask_c[0] = (y1 !== y_exp.y1);
    mask_c[1] = (y2 !== y_exp.y2);
    mask_c[2] = (y3 !== y_exp.y3);
    mask_c[3] = (y4 !== y_exp.y4);
    mask_c[4] = (y5 !== y_exp.y5);
`ifdef GATES_BIST_EXT_EN
    mask_c[5] = (y6 !== y_exp.y6);
    mask_c[6] = s && (y7 !== y_exp.y7);
`endif
  end

`ifndef GATES_BIST_EXT_EN
  logic unused_ext;
  assign unused_ext = ^{y6, y7, y_exp.y6, y_exp.y7};
`endif

  assign mismatch_c = |mask_c;
  assign last_c     = (idx == '1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      cnt       <= '0;
      a         <= '0;
      b         <= '0;
      s         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_vec  <= '0;
      fail_mask <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            err_count <= '0;
            fail_vec  <= '0;
            fail_mask <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
            idx       <= '0;
            busy      <= 1'b1;
            state     <= APPLY;
          end
        end
        APPLY: begin
          s     <= vec_c.s;
          a     <= vec_c.a;
          b     <= vec_c.b;
          cnt   <= CNT_W'(SETTLE_CYCLES);
          state <= SETTLE;
        end
        SETTLE: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= CHECK;
        end
        CHECK: begin
          if (mismatch_c) begin
            if (err_count != '1) err_count <= err_count + ERR_W'(1);
            if (err_count == '0) begin
              fail_vec  <= {s, a, b};
              fail_mask <= mask_c;
            end
          end
          if (last_c || (STOP_ON_FAIL && mismatch_c)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_count == '0) && !mismatch_c;
            state <= DONE;
          end else begin
            idx   <= idx + VEC_W'(1);
            state <= APPLY;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/gates_bist.md
Name: gates_bist

Overview:
- Synthesizable built-in self-test driver/checker for the `gates` block; it is the stimulus/response end of the gates interface.
- Drives `a`, `b` and `s` through every combination, waits a settle time, then compares `y1`..`y5` against a golden model.
- Reports pass/fail, a saturating error count and the first failing vector.
- Sits beside `gates` in the top level and replaces the simulation-only bench for on-board checks.

Parameters:
- W, 4, operand width of a/b/y buses.
- SETTLE_CYCLES, 2, cycles between applying a vector and sampling outputs (>=1).
- ERR_W, 8, width of the error counter (saturating).
- STOP_ON_FAIL, 0, if 1, end the run at the first mismatching vector.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; launches a run from IDLE or DONE.
- a  out  W  operand A to gates.
- b  out  W  operand B to gates.
- s  out  1  select to gates.
- y1..y6  in  W each  gates outputs.
- y7  in  W  gates tristate output, sampled as an input.
- busy  out  1  run in progress.
- done  out  1  run finished; held until next start.
- pass  out  1  done && err_count==0.
- err_count  out  ERR_W  mismatching vectors; saturates at all-ones.
- fail_vec  out  2W+1  {s,a,b} of the first failing vector.
- fail_mask  out  7  bit i set = y(i+1) mismatched on the first failing vector.

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-high.
- Reset values: a=0, b=0, s=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0, fail_mask=0, state=IDLE.
- Vector index `idx` is 2W+1 bits, `{s,a,b} = idx`, counting 0..2^(2W+1)-1 (512 for W=4).
- FSM states: IDLE, APPLY, SETTLE, CHECK, DONE.
- IDLE/DONE on start:
  - clear err_count, fail_vec, fail_mask, done and idx.
  - busy=1; go to APPLY.
- APPLY (1 cycle): drive {s,a,b}=idx; load the settle counter with SETTLE_CYCLES; go to SETTLE.
- SETTLE (SETTLE_CYCLES cycles): hold the vector; go to CHECK when the counter reaches 0.
- CHECK (1 cycle): compare sampled y against expected values.
  - Expected: y1=a&b, y2=a|b, y3=a^b, y4=~(a|b), y5=~(a&b).
  - Any bit mismatch counts the vector as one error. In simulation an X/Z on a checked bit is a mismatch (case-equality).
  - On the first error: capture fail_vec and fail_mask.
  - err_count increments once per failing vector and saturates at 2^ERR_W-1.
  - Next state: if idx is the last index, or (STOP_ON_FAIL and mismatch), go to DONE; otherwise idx++ and go to APPLY.
- DONE: busy=0, done=1, pass=(err_count==0). a/b/s hold the last vector.
- Latency: SETTLE_CYCLES+2 cycles per vector. Full run with W=4, SETTLE_CYCLES=2 is 2048 cycles from the start-sampled edge to done=1.
- start while busy: ignored, with no restart and no change to the counters.
- Reset mid-run: immediate return to all reset values. A fresh start is required.
- start and CHECK of the last vector in the same cycle: start is ignored, because busy is still 1.

Optional Feature:
- Macro `GATES_BIST_EXT_EN`.
- Defined:
  - also check y6 == ~(a^b).
  - also check y7 == a when s=1; y7 is not checked when s=0 (bus released).
  - fail_mask bits 5/6 become active.
- Undefined: y6/y7 are ignored; fail_mask[6:5] are tied to 0.

Decomposition:
- Package `gates_pkg`:
  - constant GATES_W=4.
  - typedef `gates_vec_t` (packed {s,a,b}).
  - enum `bist_state_t`.
  - typedef `gates_out_t` (struct of y1..y7).
- Sub-module `gates_ref_model`: combinational golden model, inputs a/b/s, outputs the expected `gates_out_t`. It is instantiated once inside gates_bist.

Test Plan:
- Real `gates` attached, start at cycle 5 -> done=1 exactly 2048 cycles later; pass=1, err_count=0, fail_mask=0.
- Stub with y1[0] stuck at 1 -> 384 failing vectors, so err_count saturates at 255; fail_vec=0, fail_mask=7'b0000001, pass=0.
- Same stub with STOP_ON_FAIL=1 -> done after 4 cycles (vector 0); err_count=1, fail_vec=0.
- Real DUT, rst pulsed at cycle 100 of a run -> all outputs at reset values within the pulse. A new start then completes in 2048 cycles with pass=1.
- Real DUT, extra start pulses at cycles 50 and 2000 of a run -> done still at cycle 2048, err_count=0.
- With `GATES_BIST_EXT_EN`, stub y6=a^b -> first fail_vec=0, fail_mask=7'b0100000; without the macro the same stub gives pass=1.
